// File: rtl/display_interface_controller.sv
// Four-digit multiplexed seven-segment driver: scans digits right to left and
// shows one of four fixed hex messages chosen by s, with the DP marking the mode.
module display_interface_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] s,
  output logic [3:0] E,
  output logic [6:0] sevenSeg,
  output logic       DP
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       p_q, p_d;
  logic [3:0]       e_q, e_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             wrap;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  always_comb begin
    wrap  = (cnt_q == CNT_MAX);
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    p_d   = wrap ? p_q + 2'd1 : p_q;
    e_d   = ~(4'b0001 << p_q);
    // Leftmost digit (p=3) carries the lowest value of the group: 3-p == ~p.
    seg_d = hex_to_seg({s, ~p_q});
    dp_d  = (p_q != s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      p_q   <= '0;
      e_q   <= 4'b1111;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
      e_q   <= e_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign E        = e_q;
  assign sevenSeg = seg_q;
  assign DP       = dp_q;

endmodule

// File: tb/tb_display_interface_controller.sv
// Directed bench for display_interface_controller with a 4-cycle digit dwell.
module tb_display_interface_controller;

  logic       clk;
  logic       rst;
  logic [1:0] s;
  logic [3:0] E;
  logic [6:0] sevenSeg;
  logic       DP;

  int n_asserts;
  int n_fails;

  display_interface_controller #(.REFRESH_DIV(4), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .s(s),
    .E(E),
    .sevenSeg(sevenSeg),
    .DP(DP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_exp,
                         input logic [6:0] seg_exp, input logic dp_exp);
    chk({tag, ".E"}, {3'b000, E}, {3'b000, e_exp});
    chk({tag, ".seg"}, sevenSeg, seg_exp);
    chk({tag, ".DP"}, {6'b0, DP}, {6'b0, dp_exp});
  endtask

  // One rising edge, then settle to the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hand-written expected segment codes, indexed [s][digit position p].
  logic [6:0] seg_tab [4][4];
  logic [3:0] e_tab [4];

  initial begin
    n_asserts = 0;
    n_fails   = 0;
    seg_tab[0] = '{7'h30, 7'h24, 7'h79, 7'h40};
    seg_tab[1] = '{7'h78, 7'h02, 7'h12, 7'h19};
    seg_tab[2] = '{7'h03, 7'h08, 7'h10, 7'h00};
    seg_tab[3] = '{7'h0E, 7'h06, 7'h21, 7'h46};
    e_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    rst = 1'b1;
    s   = 2'd0;
    step();
    chk_out("reset", 4'b1111, 7'h7F, 1'b1);
    step();
    chk_out("reset_hold", 4'b1111, 7'h7F, 1'b1);
    rst = 1'b0;

    // Four whole frames, one per mode; s changes only on frame boundaries.
    for (int m = 0; m < 4; m++) begin
      s = 2'(m);
      for (int p = 0; p < 4; p++) begin
        for (int c = 0; c < 4; c++) begin
          step();
          chk_out($sformatf("frame_s%0d_p%0d_c%0d", m, p, c), e_tab[p],
                  seg_tab[m][p], (p == m) ? 1'b0 : 1'b1);
        end
      end
    end

    // Mode change mid-digit: E and prescaler phase must be undisturbed.
    s = 2'd0;
    step();
    chk_out("mc_before", 4'b1110, 7'h30, 1'b0);
    s = 2'd3;
    step();
    chk_out("mc_after", 4'b1110, 7'h0E, 1'b1);
    step();
    chk_out("mc_hold3", 4'b1110, 7'h0E, 1'b1);
    step();
    chk_out("mc_hold4", 4'b1110, 7'h0E, 1'b1);
    step();
    chk_out("mc_next_digit", 4'b1101, 7'h06, 1'b1);
    step();
    chk_out("mc_next_digit2", 4'b1101, 7'h06, 1'b1);

    // Asynchronous reset mid-dwell, away from any clock edge.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 4'b1111, 7'h7F, 1'b1);
    step();
    chk_out("async_rst_hold", 4'b1111, 7'h7F, 1'b1);
    rst = 1'b0;

    // Scan restarts at the rightmost digit with a full dwell.
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk_out($sformatf("restart_p%0d_c%0d", p, c), e_tab[p],
                seg_tab[3][p], (p == 3) ? 1'b0 : 1'b1);
      end
    end
    step();
    chk_out("restart_wrap", 4'b1110, 7'h0E, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/display_interface_controller.md
Name: display_interface_controller

Overview:
- Drives a 4-digit, common-anode, multiplexed seven-segment display from a 100 MHz board clock.
- A 2-bit mode select `s` picks one of four 4-character hex messages: "0123", "4567", "89Ab", "CdEF".
- The decimal point marks the selected mode.
- Sits at board top level, between the slide switches and the display pins.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays enabled (1 ms at 100 MHz; full frame 4 ms). Legal range ≥2.
- CNT_W, 17, prescaler width; must satisfy 2^CNT_W ≥ REFRESH_DIV.

Ports:
- clk  in  1  system clock, 100 MHz, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- s  in  2  mode select; sampled every clock, no synchronizer required (static switches).
- E  out  4  digit enables, active-low; E[3] = leftmost digit, E[0] = rightmost.
- sevenSeg  out  7  segment cathodes, active-low, bit order {g,f,e,d,c,b,a} (bit 0 = a).
- DP  out  1  decimal-point cathode, active-low.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset state:
  - prescaler = 0; digit index p = 0.
  - E = 4'b1111 (all digits off).
  - sevenSeg = 7'b1111111; DP = 1.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap cycle, p increments mod 4: 0→1→2→3→0.
- Position p selects digit enable E[p] (E = ~(4'b0001 << p)).
  - p = 0 is rightmost; p = 3 is leftmost.
- Character at position p: nibble = {s, 2'b11 - p} = 4*s + (3 - p).
  - Leftmost digit shows the lowest value of the group; s=0 reads "0123" left to right.
- Hex decode, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- DP = 0 (lit) only when p == s, otherwise 1.
  - s=0 lights the rightmost DP; s=3 lights the leftmost DP.
- All outputs registered; computed from the current p and s each clock.
  - Latency: an s change appears on sevenSeg/DP one clock later, without waiting for a digit change.
  - E, sevenSeg and DP update on the same edge, so there is no ghosting between digits.
- Exactly one E bit is low at any time after the first clock following reset release.
- rst asserted mid-frame: outputs return immediately (asynchronously) to reset values.
  - After release, scanning restarts at p = 0 with a full REFRESH_DIV dwell.
- s changing on a prescaler wrap cycle: new p and new s are used together; no special case.

Test Plan (sim with REFRESH_DIV = 4):
- Reset: assert rst mid-scan → E=1111, sevenSeg=7F, DP=1 immediately. Release → first edge E=1110; E is held 4 cycles, then 1101, 1011, 0111, then wraps to 1110.
- s=0, one full frame: E=1110→sevenSeg=30 ('3'), DP=0; E=1101→24 ('2'), DP=1; E=1011→79 ('1'), DP=1; E=0111→40 ('0'), DP=1.
- s=1, one frame: digits E0..E3 = 78,02,12,19 ("4567"); DP=0 only while E=1101.
- s=2, then s=3, one frame each:
  - s=2: E0..E3 = 03,08,10,00 ("89Ab"); DP=0 only while E=1011.
  - s=3: E0..E3 = 0E,06,21,46 ("CdEF"); DP=0 only while E=0111.
- Mode change mid-digit: with E=1110 held and s=0, switch s to 3 → next clock sevenSeg=0E and DP=1, while E stays 1110 and prescaler phase is unchanged.
- Sequence s = 0,1,2,3,0 at 10 ms intervals, REFRESH_DIV=100000: each digit dwell is exactly 100000 cycles, and every 4 ms frame matches the expected message.
